// File: rtl/byte_data_memory.sv
// Byte-addressable 32-bit data memory: lane-masked stores and extended loads.
// A power-on sweep zeroes a configurable word range while Busy is high.
module byte_data_memory #(
  parameter int ADDR_BITS = 6,
  parameter int CLEAR_LO  = 32,
  parameter int CLEAR_HI  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] Mem_data,
  output logic        Mem_valid,
  output logic        Misaligned,
  output logic        Busy
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LP_LO = ADDR_BITS'(CLEAR_LO);
  localparam logic [ADDR_BITS-1:0] LP_HI = ADDR_BITS'(CLEAR_HI);
  localparam bit LP_SWEEP = (CLEAR_LO <= CLEAR_HI);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [ADDR_BITS-1:0] w_ptr_nxt;
  logic w_clr_we;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_mis;

  logic [ADDR_BITS-1:0] w_idx;
  logic [1:0]  w_lane;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_idle;
  logic        w_ok;
  logic        w_ld;
  logic        w_st;
  logic        w_bad;
  logic [31:0] w_rword;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_ldata;
  logic        w_unused;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clr_we    = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        if (!LP_SWEEP) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_clr_we  = 1'b1;
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == LP_HI) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_ptr   <= LP_LO;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign w_idx    = Address[ADDR_BITS+1:2];
  assign w_lane   = Address[1:0];
  assign w_unused = ^Address[31:ADDR_BITS+2];

  // Sub-word data is replicated so each lane enable picks the right bytes.
  always_comb begin
    w_mis   = 1'b0;
    w_be    = 4'b0000;
    w_wdata = Write_data;
    unique case (Size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{Write_data[7:0]}};
      end
      2'b01: begin
        w_mis   = w_lane[0];
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{Write_data[15:0]}};
      end
      2'b10: begin
        w_mis = |w_lane;
        w_be  = 4'b1111;
      end
      default: begin
        w_mis = 1'b1;
      end
    endcase
  end

  assign w_idle = (r_state == S_IDLE);
  assign w_ok   = w_idle & ~w_mis & ~reset;
  assign w_ld   = MemRead & w_ok;
  assign w_st   = MemWrite & w_ok;
  assign w_bad  = w_idle & (MemRead | MemWrite) & w_mis;

  assign w_rword = r_mem[w_idx];
  assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];
  assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_ldata = w_rword;
    unique case (Size)
      2'b00: begin
        w_ldata = Unsigned ? {24'b0, w_rbyte}
                           : {{24{w_rbyte[7]}}, w_rbyte};
      end
      2'b01: begin
        w_ldata = Unsigned ? {16'b0, w_rhalf}
                           : {{16{w_rhalf[15]}}, w_rhalf};
      end
      default: begin
        w_ldata = w_rword;
      end
    endcase
  end

  // Load data is taken before this edge's store lands: read-before-write.
  always_ff @(posedge clk) begin
    if (!reset && w_clr_we) begin
      r_mem[r_ptr] <= '0;
    end else if (w_st) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_data  <= w_ld ? w_ldata : 32'b0;
      r_valid <= w_ld;
      r_mis   <= w_bad;
    end
  end

  assign Mem_data   = r_data;
  assign Mem_valid  = r_valid;
  assign Misaligned = r_mis;
  assign Busy       = (r_state == S_CLEAR);

endmodule
